// File: rtl/ecall_io_unit.sv
// ecall I/O service unit: stalls the CPU on switch reads until a debounced press/release, latches LED/7-seg writes.
// Optional build macro IO_ECHO_EN: mirror every captured read value onto the LEDs.
module ecall_io_unit #(
    parameter int              CNT_W           = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [2:0]  io_code,
    input  logic [31:0] io_wdata,
    input  logic [15:0] switch,
    input  logic        confirm_btn,
    output logic [31:0] io_rdata,
    output logic        io_stall,
    output logic        io_done,
    output logic [15:0] led,
    output logic [31:0] seg_value
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = DEBOUNCE_CYCLES - 1'b1;

    state_t           state;
    state_t           state_next;
    logic             btn_s1;
    logic             btn_s2;
    logic             btn_stable;
    logic             btn_prev;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      sw_s1;
    logic [15:0]      sw_s2;
    logic [2:0]       code_q;
    logic             btn_rise;
    logic             btn_fall;
    logic             capture;
    logic             write_led;
    logic             write_seg;
    logic [31:0]      read_value;

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= confirm_btn;
            btn_s2 <= btn_s1;
            sw_s1  <= switch;
            sw_s2  <= sw_s1;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_stable <= 1'b0;
            btn_prev   <= 1'b0;
            cnt        <= '0;
        end else begin
            btn_prev <= btn_stable;
            if (btn_s2 == btn_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_stable <= btn_s2;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_rise = btn_stable & ~btn_prev;
    assign btn_fall = ~btn_stable & btn_prev;

    always_comb begin
        read_value = {16'b0, sw_s2};
        case (code_q)
            3'd1:    read_value = {{16{sw_s2[15]}}, sw_s2};
            3'd2:    read_value = {24'b0, sw_s2[7:0]};
            3'd3:    read_value = {31'b0, sw_s2[0]};
            default: read_value = {16'b0, sw_s2};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        io_stall   = 1'b0;
        io_done    = 1'b0;
        capture    = 1'b0;
        write_led  = 1'b0;
        write_seg  = 1'b0;
        case (state)
            IDLE: begin
                if (IORead) begin
                    io_stall   = 1'b1;
                    state_next = WAIT_PRESS;
                end else if (IOWrite) begin
                    write_led = (io_code == 3'd4);
                    write_seg = (io_code == 3'd5);
                end
            end
            WAIT_PRESS: begin
                io_stall = 1'b1;
                if (btn_rise) begin
                    capture    = 1'b1;
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                io_stall = 1'b1;
                if (btn_fall) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                io_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The sub-function is latched at request time; io_code may change while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            code_q    <= 3'd0;
            io_rdata  <= '0;
            led       <= '0;
            seg_value <= '0;
        end else begin
            if (state == IDLE && IORead) begin
                code_q <= io_code;
            end
            if (capture) begin
                io_rdata <= read_value;
            end
            if (write_led) begin
                led <= io_wdata[15:0];
            end
`ifdef IO_ECHO_EN
            if (capture) begin
                led <= read_value[15:0];
            end
`else
`endif
            if (write_seg) begin
                seg_value <= io_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ecall_io_unit.sv
// Directed self-checking bench for ecall_io_unit with DEBOUNCE_CYCLES=4.
module tb_ecall_io_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        IORead;
    logic        IOWrite;
    logic [2:0]  io_code;
    logic [31:0] io_wdata;
    logic [15:0] switch;
    logic        confirm_btn;
    logic [31:0] io_rdata;
    logic        io_stall;
    logic        io_done;
    logic [15:0] led;
    logic [31:0] seg_value;

    int checks = 0;
    int passed = 0;

    logic [15:0] exp_led;
    logic [31:0] exp_seg;
    logic [31:0] exp_rdata;

    always #5 clock = ~clock;

    ecall_io_unit #(
        .CNT_W(20),
        .DEBOUNCE_CYCLES(20'd4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .IORead(IORead),
        .IOWrite(IOWrite),
        .io_code(io_code),
        .io_wdata(io_wdata),
        .switch(switch),
        .confirm_btn(confirm_btn),
        .io_rdata(io_rdata),
        .io_stall(io_stall),
        .io_done(io_done),
        .led(led),
        .seg_value(seg_value)
    );

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic hold_btn(input logic level, input int n, inout bit stall_bad, inout bit done_seen);
        confirm_btn = level;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!io_stall) stall_bad = 1'b1;
            if (io_done) done_seen = 1'b1;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output bit stall_bad);
        seen = 1'b0;
        stall_bad = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (io_done) seen = 1'b1;
            else begin
                if (!io_stall) stall_bad = 1'b1;
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; IORead = 1'b1; IOWrite = 1'b0; io_code = 3'd0; io_wdata = '0;
        switch = '0; confirm_btn = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (led !== 16'h0) $display("FAIL rst_led: got %h want %h", led, 16'h0); else passed++;
        checks++; if (seg_value !== 32'h0) $display("FAIL rst_seg: got %h want %h", seg_value, 32'h0); else passed++;
        checks++; if (io_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want %h", io_rdata, 32'h0); else passed++;
        checks++; if (io_done !== 1'b0) $display("FAIL rst_done: got %b want 0", io_done); else passed++;
        checks++; if (io_stall !== 1'b1) $display("FAIL rst_stall_hi: got %b want 1", io_stall); else passed++;
        IORead = 1'b0;
        #1;
        checks++; if (io_stall !== 1'b0) $display("FAIL rst_stall_lo: got %b want 0", io_stall); else passed++;
        exp_led = 16'h0; exp_seg = 32'h0; exp_rdata = 32'h0;
        tick();
    endtask

    task automatic test_writes();
        bit stall_seen = 1'b0;
        IOWrite = 1'b1; io_code = 3'd4; io_wdata = 32'h1234ABCD;
        #1; if (io_stall) stall_seen = 1'b1;
        tick();
        checks++; if (led !== 16'hABCD) $display("FAIL wr_led: got %h want %h", led, 16'hABCD); else passed++;
        checks++; if (seg_value !== 32'h0) $display("FAIL wr_led_seg: got %h want %h", seg_value, 32'h0); else passed++;
        io_code = 3'd5; io_wdata = 32'hDEADBEEF;
        #1; if (io_stall) stall_seen = 1'b1;
        tick();
        checks++; if (seg_value !== 32'hDEADBEEF) $display("FAIL wr_seg: got %h want %h", seg_value, 32'hDEADBEEF); else passed++;
        io_code = 3'd6; io_wdata = 32'h0;
        #1; if (io_stall) stall_seen = 1'b1;
        tick();
        io_code = 3'd3;
        #1; if (io_stall) stall_seen = 1'b1;
        tick();
        IOWrite = 1'b0;
        checks++; if (led !== 16'hABCD) $display("FAIL wr_other_led: got %h want %h", led, 16'hABCD); else passed++;
        checks++; if (seg_value !== 32'hDEADBEEF) $display("FAIL wr_other_seg: got %h want %h", seg_value, 32'hDEADBEEF); else passed++;
        checks++; if (stall_seen !== 1'b0) $display("FAIL wr_stall: got %b want 0", stall_seen); else passed++;
        exp_led = 16'hABCD; exp_seg = 32'hDEADBEEF;
    endtask

    task automatic test_signed_read();
        bit sb = 1'b0, ds = 1'b0, seen, sb2;
        switch = 16'h8001;
        tick(); tick(); tick();
        IORead = 1'b1; io_code = 3'd1;
        #1;
        checks++; if (io_stall !== 1'b1) $display("FAIL sr_stall_req: got %b want 1", io_stall); else passed++;
        tick();
        hold_btn(1'b1, 10, sb, ds);
        checks++; if (io_rdata !== 32'hFFFF8001) $display("FAIL sr_capture: got %h want %h", io_rdata, 32'hFFFF8001); else passed++;
        confirm_btn = 1'b0;
        wait_done(20, seen, sb2);
        checks++; if (seen !== 1'b1) $display("FAIL sr_done_timeout: got %b want 1", seen); else passed++;
        checks++; if ((sb | sb2 | ds) !== 1'b0) $display("FAIL sr_stall_gap: got %b want 0", sb | sb2 | ds); else passed++;
        checks++; if (io_stall !== 1'b0) $display("FAIL sr_done_stall: got %b want 0", io_stall); else passed++;
        checks++; if (io_rdata !== 32'hFFFF8001) $display("FAIL sr_rdata: got %h want %h", io_rdata, 32'hFFFF8001); else passed++;
        IORead = 1'b0;
        tick();
        checks++; if (io_done !== 1'b0) $display("FAIL sr_done_pulse: got %b want 0", io_done); else passed++;
        checks++; if (io_stall !== 1'b0) $display("FAIL sr_idle_stall: got %b want 0", io_stall); else passed++;
        checks++; if (io_rdata !== 32'hFFFF8001) $display("FAIL sr_hold: got %h want %h", io_rdata, 32'hFFFF8001); else passed++;
        exp_rdata = 32'hFFFF8001;
`ifdef IO_ECHO_EN
        exp_led = 16'h8001;
`endif
        checks++; if (led !== exp_led) $display("FAIL sr_led: got %h want %h", led, exp_led); else passed++;
    endtask

    task automatic test_glitch();
        bit sb = 1'b0, ds = 1'b0, seen, sb2;
        switch = 16'h0001;
        tick(); tick(); tick();
        IORead = 1'b1; io_code = 3'd3;
        tick();
        for (int k = 0; k < 3; k++) begin
            hold_btn(1'b1, 2, sb, ds);
            hold_btn(1'b0, 4, sb, ds);
        end
        checks++; if ((sb | ds) !== 1'b0) $display("FAIL gl_stall_done: got %b want 0", sb | ds); else passed++;
        checks++; if (io_rdata !== exp_rdata) $display("FAIL gl_no_capture: got %h want %h", io_rdata, exp_rdata); else passed++;
        checks++; if (io_stall !== 1'b1) $display("FAIL gl_stall: got %b want 1", io_stall); else passed++;
        hold_btn(1'b1, 10, sb, ds);
        confirm_btn = 1'b0;
        wait_done(20, seen, sb2);
        checks++; if (seen !== 1'b1) $display("FAIL gl_done_timeout: got %b want 1", seen); else passed++;
        checks++; if (io_rdata !== 32'h00000001) $display("FAIL gl_rdata: got %h want %h", io_rdata, 32'h00000001); else passed++;
        IORead = 1'b0;
        tick();
        exp_rdata = 32'h00000001;
`ifdef IO_ECHO_EN
        exp_led = 16'h0001;
`endif
        checks++; if (led !== exp_led) $display("FAIL gl_led: got %h want %h", led, exp_led); else passed++;
    endtask

    task automatic test_held_button();
        bit sb = 1'b0, ds = 1'b0, seen, sb2;
        confirm_btn = 1'b1;
        repeat (10) tick();
        switch = 16'h00F5; io_code = 3'd2; IORead = 1'b1;
        tick();
        hold_btn(1'b1, 10, sb, ds);
        checks++; if (io_rdata !== exp_rdata) $display("FAIL hb_held: got %h want %h", io_rdata, exp_rdata); else passed++;
        hold_btn(1'b0, 10, sb, ds);
        checks++; if (io_rdata !== exp_rdata) $display("FAIL hb_release: got %h want %h", io_rdata, exp_rdata); else passed++;
        checks++; if ((sb | ds) !== 1'b0) $display("FAIL hb_stall_done: got %b want 0", sb | ds); else passed++;
        hold_btn(1'b1, 10, sb, ds);
        confirm_btn = 1'b0;
        wait_done(20, seen, sb2);
        checks++; if (seen !== 1'b1) $display("FAIL hb_done_timeout: got %b want 1", seen); else passed++;
        checks++; if (io_rdata !== 32'h000000F5) $display("FAIL hb_rdata: got %h want %h", io_rdata, 32'h000000F5); else passed++;
        IORead = 1'b0;
        tick();
        exp_rdata = 32'h000000F5;
`ifdef IO_ECHO_EN
        exp_led = 16'h00F5;
`endif
    endtask

    task automatic test_collision();
        bit sb = 1'b0, ds = 1'b0, seen, sb2;
        switch = 16'h0F0F;
        tick(); tick(); tick();
        IORead = 1'b1; IOWrite = 1'b1; io_code = 3'd0; io_wdata = 32'h5555AAAA;
        tick();
        checks++; if (led !== exp_led) $display("FAIL co_led: got %h want %h", led, exp_led); else passed++;
        io_code = 3'd5;
        hold_btn(1'b1, 10, sb, ds);
        confirm_btn = 1'b0;
        wait_done(20, seen, sb2);
        checks++; if (seen !== 1'b1) $display("FAIL co_done_timeout: got %b want 1", seen); else passed++;
        checks++; if (seg_value !== exp_seg) $display("FAIL co_seg: got %h want %h", seg_value, exp_seg); else passed++;
        checks++; if (io_rdata !== 32'h00000F0F) $display("FAIL co_rdata: got %h want %h", io_rdata, 32'h00000F0F); else passed++;
        IORead = 1'b0; IOWrite = 1'b0;
        tick();
`ifdef IO_ECHO_EN
        exp_led = 16'h0F0F;
`endif
        checks++; if (led !== exp_led) $display("FAIL co_echo_led: got %h want %h", led, exp_led); else passed++;

        switch = 16'h8001;
        tick(); tick(); tick();
        IORead = 1'b1; IOWrite = 1'b1; io_code = 3'd4; io_wdata = 32'h11112222;
        tick();
        checks++; if (led !== exp_led) $display("FAIL co4_led: got %h want %h", led, exp_led); else passed++;
        hold_btn(1'b1, 10, sb, ds);
        confirm_btn = 1'b0;
        wait_done(20, seen, sb2);
        checks++; if (seen !== 1'b1) $display("FAIL co4_done_timeout: got %b want 1", seen); else passed++;
        checks++; if (io_rdata !== 32'h00008001) $display("FAIL co4_rdata: got %h want %h", io_rdata, 32'h00008001); else passed++;
        IORead = 1'b0; IOWrite = 1'b0;
        tick();
        exp_rdata = 32'h00008001;
`ifdef IO_ECHO_EN
        exp_led = 16'h8001;
`endif
    endtask

    task automatic test_reset_mid_read();
        bit sb = 1'b0, ds = 1'b0;
        switch = 16'h1234;
        tick(); tick(); tick();
        IORead = 1'b1; io_code = 3'd0;
        tick();
        hold_btn(1'b1, 10, sb, ds);
        checks++; if (io_rdata !== 32'h00001234) $display("FAIL mr_capture: got %h want %h", io_rdata, 32'h00001234); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0; IORead = 1'b0; confirm_btn = 1'b0;
        #1;
        checks++; if (io_rdata !== 32'h0) $display("FAIL mr_rdata: got %h want %h", io_rdata, 32'h0); else passed++;
        checks++; if (led !== 16'h0) $display("FAIL mr_led: got %h want %h", led, 16'h0); else passed++;
        checks++; if (seg_value !== 32'h0) $display("FAIL mr_seg: got %h want %h", seg_value, 32'h0); else passed++;
        checks++; if (io_stall !== 1'b0) $display("FAIL mr_stall: got %b want 0", io_stall); else passed++;
        ds = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (io_done || io_stall) ds = 1'b1;
        end
        checks++; if (ds !== 1'b0) $display("FAIL mr_idle: got %b want 0", ds); else passed++;
    endtask

    initial begin
        test_reset();
        test_writes();
        test_signed_read();
        test_glitch();
        test_held_button();
        test_collision();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
